// File: rtl/mc_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : Shared state encoding, opcodes and datapath-select encodings for
//          the multicycle MIPS controller.
// Rev    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_ALUWB   = 4'd3,
        ST_ADDIEX  = 4'd4,
        ST_ADDIWB  = 4'd5,
        ST_BRANCH  = 4'd6,
        ST_JUMP    = 4'd7,
        ST_JAL     = 4'd8,
        ST_MEMADR  = 4'd9,
        ST_MEMRD   = 4'd10,
        ST_MEMWB   = 4'd11,
        ST_MEMWR   = 4'd12,
        ST_ILLEGAL = 4'd13,
        ST_BUSERR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mc_wait_timer
// Brief  : Saturating wait-state counter; flags expiry at MAX_WAIT cycles.
// Rev    : 1.0  initial release
// ============================================================================
module mc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    // With no timeout the counter just parks at all-ones instead of wrapping.
    localparam logic [CNT_W-1:0] c_sat = (MAX_WAIT == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_sat)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (MAX_WAIT != 0) && (r_cnt == c_sat);

endmodule
`default_nettype wire

// File: rtl/mc_maindec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mc_maindec
// Brief  : Multicycle main decoder FSM with memory wait states, timeout and
//          illegal-opcode trapping; one write enable per data-memory bank.
// Rev    : 1.0  initial release
// ============================================================================
module mc_maindec
    import mc_ctrl_pkg::*;
#(
    parameter int NUM_DM   = 4,
    parameter int MAX_WAIT = 15,
    parameter int BANK_W   = (NUM_DM > 1) ? $clog2(NUM_DM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [BANK_W-1:0] dm_bank,
    input  logic              im_ready,
    input  logic              dm_ready,
    output logic              mem_req,
    output logic              pc_we,
    output logic              ir_we,
    output logic              branch,
    output logic              jump,
    output logic              jal,
    output logic              reg_dst,
    output logic              we_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              dm2reg,
    output logic [1:0]        alu_op,
    output logic [NUM_DM-1:0] we_dm,
    output logic              illegal,
    output logic              bus_err
);

    localparam logic [BANK_W:0] c_num_dm = (BANK_W + 1)'(NUM_DM);

    state_t            r_state;
    state_t            w_next;
    logic [BANK_W-1:0] r_bank_q;
    logic              r_is_sw;
    logic              w_ready;
    logic              w_waiting;
    logic              w_expired;
    logic              w_bank_bad;

    assign w_ready    = (r_state == ST_FETCH) ? im_ready : dm_ready;
    assign w_waiting  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    assign w_bank_bad = {1'b0, dm_bank} >= c_num_dm;

    // Any state change clears the counter, so each wait state starts from zero.
    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_next != r_state),
        .inc     (w_waiting && !w_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_bank_q <= '0;
            r_is_sw  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) r_is_sw  <= (opcode == OP_SW);
            if (r_state == ST_MEMADR) r_bank_q <= dm_bank;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        reg_dst   = 1'b0;
        we_reg    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = ALU_SRC_B_RT;
        dm2reg    = 1'b0;
        alu_op    = ALU_OP_ADD;
        illegal   = 1'b0;
        bus_err   = 1'b0;

        // Ready wins over expiry when both land in the same cycle.
        case (r_state)
            ST_FETCH:  if (im_ready) w_next = ST_DECODE; else if (w_expired) w_next = ST_BUSERR;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_JAL:       w_next = ST_JAL;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    default:      w_next = ST_ILLEGAL;
                endcase
            end
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ADDIEX: w_next = ST_ADDIWB;
            ST_MEMADR: begin
                if (w_bank_bad)   w_next = ST_BUSERR;
                else if (r_is_sw) w_next = ST_MEMWR;
                else              w_next = ST_MEMRD;
            end
            ST_MEMRD:  if (dm_ready) w_next = ST_MEMWB; else if (w_expired) w_next = ST_BUSERR;
            ST_MEMWR:  if (dm_ready) w_next = ST_FETCH; else if (w_expired) w_next = ST_BUSERR;
            default:   w_next = ST_FETCH;
        endcase

        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    pc_we     = im_ready;
                    ir_we     = im_ready;
                    alu_src_b = ALU_SRC_B_FOUR;
                end
                ST_DECODE: alu_src_b = ALU_SRC_B_IMM_SH2;
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                ST_ALUWB: begin
                    we_reg  = 1'b1;
                    reg_dst = 1'b1;
                end
                ST_ADDIEX, ST_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                end
                ST_ADDIWB: we_reg = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_SUB;
                    branch    = 1'b1;
                end
                ST_JUMP: jump = 1'b1;
                ST_JAL: begin
                    jump   = 1'b1;
                    jal    = 1'b1;
                    we_reg = 1'b1;
                end
                ST_MEMRD, ST_MEMWR: mem_req = 1'b1;
                ST_MEMWB: begin
                    we_reg = 1'b1;
                    dm2reg = 1'b1;
                end
                ST_ILLEGAL: illegal = 1'b1;
                ST_BUSERR:  bus_err = 1'b1;
                default: ;
            endcase
        end
    end

    // bank_q is range-checked before MEMWR, so at most one bit can match.
    for (genvar i = 0; i < NUM_DM; i++) begin : g_we_dm
        assign we_dm[i] = !rst && (r_state == ST_MEMWR) && (r_bank_q == BANK_W'(i));
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_maindec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mc_maindec
// Brief  : Scoreboard bench for mc_maindec (NUM_DM=4 and NUM_DM=3 instances).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mc_maindec;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req, pc_we, ir_we, branch, jump, jal, reg_dst, we_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic       dm2reg;
        logic [1:0] alu_op;
        logic [3:0] we_dm;
        logic       illegal, bus_err;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t v;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [1:0] dm_bank = '0;
    logic       im_ready = 1'b0, dm_ready = 1'b0;
    logic       mem_req, pc_we, ir_we, branch, jump, jal, reg_dst, we_reg, alu_src_a, dm2reg;
    logic       illegal, bus_err;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] we_dm;

    logic [5:0] opcode3 = '0;
    logic [1:0] dm_bank3 = '0;
    logic       im_ready3 = 1'b0, dm_ready3 = 1'b0;
    logic       mem_req3, pc_we3, ir_we3, branch3, jump3, jal3, reg_dst3, we_reg3, alu_src_a3, dm2reg3;
    logic       illegal3, bus_err3;
    logic [1:0] alu_src_b3, alu_op3;
    logic [2:0] we_dm3;

    mc_maindec #(.NUM_DM(4), .MAX_WAIT(15)) u_dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .dm_bank(dm_bank),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .mem_req(mem_req), .pc_we(pc_we), .ir_we(ir_we), .branch(branch), .jump(jump),
        .jal(jal), .reg_dst(reg_dst), .we_reg(we_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .dm2reg(dm2reg), .alu_op(alu_op), .we_dm(we_dm),
        .illegal(illegal), .bus_err(bus_err)
    );

    mc_maindec #(.NUM_DM(3), .MAX_WAIT(4)) u_dut3 (
        .clk(clk), .rst(rst), .opcode(opcode3), .dm_bank(dm_bank3),
        .im_ready(im_ready3), .dm_ready(dm_ready3),
        .mem_req(mem_req3), .pc_we(pc_we3), .ir_we(ir_we3), .branch(branch3), .jump(jump3),
        .jal(jal3), .reg_dst(reg_dst3), .we_reg(we_reg3), .alu_src_a(alu_src_a3),
        .alu_src_b(alu_src_b3), .dm2reg(dm2reg3), .alu_op(alu_op3), .we_dm(we_dm3),
        .illegal(illegal3), .bus_err(bus_err3)
    );

    outs_t      o4;
    logic [7:0] o3;
    assign o4 = {mem_req, pc_we, ir_we, branch, jump, jal, reg_dst, we_reg, alu_src_a,
                 alu_src_b, dm2reg, alu_op, we_dm, illegal, bus_err};
    assign o3 = {bus_err3, we_dm3, jump3, jal3, we_reg3, mem_req3};

    // {bus_err, we_dm[2:0], jump, jal, we_reg, mem_req} per cycle after release
    localparam logic [7:0] c_exp3 [17] = '{
        8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h01, 8'h00, 8'h00,
        8'h80, 8'h01, 8'h00, 8'h0E, 8'h01, 8'h00, 8'h00, 8'h41
    };

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    exp_t m_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_event(outs_t o);
        return o.ir_we | o.we_reg | (|o.we_dm) | o.illegal | o.bus_err | o.branch | o.jump;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input outs_t v, input string name);
        exp_t x;
        x.cyc  = c;
        x.v    = v;
        x.name = name;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && is_event(o4)) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %h at cycle %0d, nothing expected", o4, cyc);
            end else begin
                m_e = q.pop_front();
                if (o4 !== m_e.v || cyc != m_e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                             m_e.name, o4, cyc, m_e.v, m_e.cyc);
                end
            end
        end
    end

    // Starts at the first cycle of FETCH; returns at the first cycle of the next FETCH.
    task automatic do_instr(input string name, input logic [5:0] op, input int fw,
                            input logic [1:0] bank, input int dwait);
        int    tf;
        int    n;
        outs_t e;
        tf      = cyc + fw;
        opcode  = op;
        dm_bank = bank;
        e = '0; e.mem_req = 1'b1; e.pc_we = 1'b1; e.ir_we = 1'b1; e.alu_src_b = 2'b01;
        push(tf, e, {name, "_fetch"});
        e = '0;
        n = 3;
        case (op)
            OP_RTYPE: begin e.we_reg = 1'b1; e.reg_dst = 1'b1; push(tf + 3, e, {name, "_wb"}); n = 4; end
            OP_ADDI:  begin e.we_reg = 1'b1; push(tf + 3, e, {name, "_wb"}); n = 4; end
            OP_BEQ:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.branch = 1'b1; push(tf + 2, e, {name, "_br"}); end
            OP_J:     begin e.jump = 1'b1; push(tf + 2, e, {name, "_jump"}); end
            OP_JAL:   begin e.jump = 1'b1; e.jal = 1'b1; e.we_reg = 1'b1; push(tf + 2, e, {name, "_jal"}); end
            OP_LW: begin
                if (dwait > 15) begin
                    e.bus_err = 1'b1; push(tf + 19, e, {name, "_buserr"}); n = 20;
                end else begin
                    e.we_reg = 1'b1; e.dm2reg = 1'b1; push(tf + 4 + dwait, e, {name, "_wb"}); n = 5 + dwait;
                end
            end
            OP_SW: begin
                e.mem_req = 1'b1;
                e.we_dm   = 4'b0001 << bank;
                for (int i = 0; i <= dwait; i++) push(tf + 3 + i, e, {name, "_memwr"});
                n = 4 + dwait;
            end
            default: begin e.illegal = 1'b1; push(tf + 2, e, {name, "_trap"}); end
        endcase
        for (int c = 0; c < fw + n; c++) begin
            im_ready = (c >= fw);
            dm_ready = (c >= fw + 3 + dwait);
            if (op == OP_RTYPE && c == fw + 2) begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                chk({name, "_exec"}, 32'(o4), 32'(e));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        int    tf;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out4", 32'(o4), 32'h0);
        chk("reset_out3", 32'(o3), 32'h0);
        rst = 1'b0;
        #1;
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
        chk("release_fetch", 32'(o4), 32'(e));
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_instr("rtype",   OP_RTYPE, 0, 2'd0, 0);
        do_instr("addi",    OP_ADDI,  0, 2'd0, 0);
        do_instr("beq",     OP_BEQ,   0, 2'd0, 0);
        do_instr("j",       OP_J,     0, 2'd0, 0);
        do_instr("jal",     OP_JAL,   0, 2'd0, 0);
        do_instr("lw",      OP_LW,    0, 2'd1, 0);
        do_instr("sw_wait", OP_SW,    0, 2'd2, 3);
        do_instr("lw_tout", OP_LW,    0, 2'd0, 100);
        do_instr("illegal", 6'h3F,    0, 2'd0, 0);
        do_instr("rt_fw2",  OP_RTYPE, 2, 2'd0, 0);
        do_instr("lw_edge", OP_LW,    0, 2'd3, 15);
        do_instr("sw_fw1",  OP_SW,    1, 2'd0, 0);

        // Store stalled in MEMWR, then async reset lands mid-access.
        tf = cyc;
        opcode = OP_SW; dm_bank = 2'd3;
        e = '0; e.mem_req = 1'b1; e.pc_we = 1'b1; e.ir_we = 1'b1; e.alu_src_b = 2'b01;
        push(tf, e, "sw_rst_fetch");
        e = '0; e.mem_req = 1'b1; e.we_dm = 4'b1000;
        push(tf + 3, e, "sw_rst_memwr");
        push(tf + 4, e, "sw_rst_memwr");
        for (int c = 0; c < 5; c++) begin
            im_ready = 1'b1;
            dm_ready = 1'b0;
            @(posedge clk); #1;
        end
        chk("pre_reset_we_dm", 32'(we_dm), 32'h8);
        rst = 1'b1;
        #1;
        chk("reset_mid_memwr", 32'(o4), 32'h0);
        chk("reset_mid_dut3", 32'(o3), 32'h0);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        mon_en   = 1'b0;
        im_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset_held", 32'(o4), 32'h0);
        rst = 1'b0;
        #1;
        e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
        chk("release_fetch2", 32'(o4), 32'(e));

        // NUM_DM=3 / MAX_WAIT=4 instance: fetch timeout, bad bank, JAL, good store.
        for (int k = 0; k < 17; k++) begin
            im_ready3 = (k >= 6);
            dm_ready3 = 1'b1;
            opcode3   = (k < 10) ? OP_SW : ((k < 13) ? OP_JAL : OP_SW);
            dm_bank3  = (k < 13) ? 2'd3 : 2'd2;
            @(negedge clk);
            chk($sformatf("dut3_k%0d", k), 32'(o3), 32'(c_exp3[k]));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
